calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sequences one calculator transaction end to end.
  - Accepts one-shot key events from the switch front end: digits, operators, equals, clear.
  - Assembles two decimal operands and runs the arithmetic.
  - Converts the result to BCD and streams ASCII characters into the 32-entry LCD text buffer that the LCD refresh FSM scans.
- Sits between the switch debounce/one-shot logic and the LCD controller. It is the only writer of the text buffer.

Parameters:
- DIGITS, 4, maximum decimal digits per operand.
- OP_W, 14, operand width in bits. Must satisfy 2^OP_W > 10^DIGITS - 1.
- RES_W, 28, result magnitude width. Equals 2*OP_W.

Ports:
- clk_100hz  in  1  system tick; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  key code:
  - 0-9 digit
  - 10 '+', 11 '-', 12 '*', 13 '/'
  - 14 '='
  - 15 clear
- key_ready  out  1  high when a key can be accepted.
- disp_we  out  1  text-buffer write strobe.
- disp_addr  out  5  buffer address: 0-15 is line1, 16-31 is line2.
- disp_data  out  8  ASCII / LCD character code.
- busy  out  1  high in any state other than ENT_A, ENT_B, DONE.
- err  out  1  sticky divide-by-zero flag.

Behaviour:
- Reset values: key_ready=0, disp_we=0, disp_addr=0, disp_data=8'h20, busy=1, err=0. State=CLR. A=B=0. Digit counters=0. Line1 cursor=0.
- Keys are sampled only when key_valid && key_ready. Keys arriving otherwise are dropped with no side effect.
- Exception: clear (15) is accepted in every state, including busy states.
- key_ready=1 only in ENT_A, ENT_B, DONE.
- FSM states: CLR, ENT_A, ENT_B, CALC, DIV, CONV, EMIT, DONE.
- CLR:
  - 32 cycles, writing 8'h20 to addresses 0..31 in order.
  - Then goes to ENT_A. Clears err, A, B, cursor.
  - Entered from reset and on any clear key. A clear key aborts any operation mid-flight.
- ENT_A:
  - Digit: if count<DIGITS, A=A*10+d and echo the character. Otherwise ignore the digit.
  - Operator: latch op, echo it, go to ENT_B. An operator with no digits entered uses A=0.
  - '=': result=A, go to CONV.
- ENT_B:
  - Digits: same rule as ENT_A, applied to B.
  - Operator: ignored.
  - '=': echo '=', go to CALC.
- Echo timing:
  - disp_we pulses the cycle after acceptance, at disp_addr=cursor; cursor then increments.
  - Writes at cursor>15 are suppressed.
- CALC (1 cycle):
  - '+' : A+B.
  - '-' : sign-magnitude result. If B>A then neg=1 and magnitude=B-A.
  - '*' : full RES_W product.
  - '/' : if B==0, set err and go to EMIT. Otherwise go to DIV.
- DIV:
  - Restoring unsigned divider, exactly OP_W cycles.
  - Quotient truncates toward zero.
- CONV:
  - Double-dabble, exactly RES_W cycles.
  - Produces 2*DIGITS BCD digits.
- EMIT: 16 consecutive writes, addresses 16..31.
  - Line2 is right-aligned.
  - Leading zeros are blanked. A zero result shows "0".
  - '-' is placed immediately left of the most significant digit.
  - When err=1, line2 is blanks ending in "Err".
- DONE:
  - Waits for clear. All other keys are ignored.
- Latency from '=' acceptance to last line2 write:
  - '+', '-', '*': 1+RES_W+16 = 45 cycles.
  - '/': 1+OP_W+RES_W+16 = 59 cycles.
- Reset mid-operation: immediate return to the reset values; the CLR sweep restarts.

Optional Feature:
- Macro: CALC_DIV_ROUND_EN.
- Defined: after DIV, if 2*remainder >= B, the quotient is incremented (round half up). Adds 1 cycle in DIV.
- Undefined: truncating quotient; DIV takes OP_W cycles.

Decomposition:
- Package calc_pkg holds:
  - key code constants
  - state encoding
  - LCD character constants: digits 8'h30-8'h39, '+' 8'h2B, '-' 8'h2D, '*' 8'hD7, '/' 8'hF7, '=' 8'h3D, blank 8'h20, "Err"
- One sub-module, calc_divider.
  - Iterative restoring divider with start/done handshake.
  - Parameterized by OP_W.

Test Plan:
- Keys 1,2,+,3,4,= -> line1 writes "12+34=" at addresses 0-5; line2 shows "46" at addresses 30-31, addresses 16-29 blank; final write 45 cycles after '='.
- Keys 5,-,9,= -> line2 "-4" at addresses 30-31; err=0.
- Keys 9,9,9,9,*,9,9,9,9,= -> line2 "99980001" at addresses 24-31.
- Keys 7,/,0,= -> err=1; line2 "Err" at addresses 29-31. A following clear -> 32 blank writes, then err=0, key_ready=1.
- Keys 7,/,2,= -> line2 "3". With CALC_DIV_ROUND_EN -> "4". Clear issued 5 cycles into DIV -> division aborts, CLR sweep runs, no line2 result written.
- Keys 1,2,3,4,5,+ -> A=1234; digit 5 is not echoed; '+' echoed at address 4. key_valid pulses while busy=1 (non-clear) -> no writes, no state change.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, FSM/operator encodings and LCD character codes for the calculator slice.
package calc_pkg;

    localparam logic [3:0] KeyAdd = 4'd10;
    localparam logic [3:0] KeySub = 4'd11;
    localparam logic [3:0] KeyMul = 4'd12;
    localparam logic [3:0] KeyDiv = 4'd13;
    localparam logic [3:0] KeyEq  = 4'd14;
    localparam logic [3:0] KeyClr = 4'd15;

    typedef enum logic [2:0] {
        StClr, StEntA, StEntB, StCalc, StDiv, StConv, StEmit, StDone
    } state_e;

    typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

    localparam logic [7:0] ChZero   = 8'h30;
    localparam logic [7:0] ChPlus   = 8'h2B;
    localparam logic [7:0] ChMinus  = 8'h2D;
    localparam logic [7:0] ChTimes  = 8'hD7;
    localparam logic [7:0] ChDivide = 8'hF7;
    localparam logic [7:0] ChEq     = 8'h3D;
    localparam logic [7:0] ChBlank  = 8'h20;
    localparam logic [7:0] ChE      = 8'h45;
    localparam logic [7:0] ChR      = 8'h72;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ChZero + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input op_e op);
        case (op)
            OpAdd:   return ChPlus;
            OpSub:   return ChMinus;
            OpMul:   return ChTimes;
            default: return ChDivide;
        endcase
    endfunction

endpackage

// File: rtl/calc_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, start/done handshake.
// Define CALC_DIV_ROUND_EN to add one round-half-up cycle after the last iteration.
module calc_divider #(
    parameter int unsigned OP_W = 14
) (
    input  logic            clk_100hz,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] dividend,
    input  logic [OP_W-1:0] divisor,
    output logic [OP_W-1:0] quotient,
    output logic            done
);
    localparam int unsigned CntW = $clog2(OP_W + 1);

    logic [OP_W-1:0] rem_q, quo_q, dvs_q;
    logic [CntW-1:0] cnt_q;
    logic            run_q, done_q;
    logic [OP_W-1:0] rem_in, quo_in, dvs_in, rem_nx, quo_nx;
    logic [OP_W:0]   trial;
    logic            q_bit;
`ifdef CALC_DIV_ROUND_EN
    logic            round_q;
`endif

    // The start cycle already performs the first iteration on the fresh operands.
    always_comb begin
        rem_in = start ? '0 : rem_q;
        quo_in = start ? dividend : quo_q;
        dvs_in = start ? divisor : dvs_q;
        trial  = {rem_in, quo_in[OP_W-1]};
        q_bit  = trial >= {1'b0, dvs_in};
        rem_nx = q_bit ? OP_W'(trial - {1'b0, dvs_in}) : trial[OP_W-1:0];
        quo_nx = {quo_in[OP_W-2:0], q_bit};
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef CALC_DIV_ROUND_EN
            round_q <= 1'b0;
`endif
        end else if (start) begin
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            dvs_q   <= divisor;
            cnt_q   <= CntW'(1);
            run_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef CALC_DIV_ROUND_EN
            round_q <= 1'b0;
`endif
        end else if (run_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(OP_W - 1)) begin
                run_q   <= 1'b0;
`ifdef CALC_DIV_ROUND_EN
                round_q <= 1'b1;
`else
                done_q  <= 1'b1;
`endif
            end
`ifdef CALC_DIV_ROUND_EN
        end else if (round_q) begin
            round_q <= 1'b0;
            done_q  <= 1'b1;
            if ({rem_q, 1'b0} >= {1'b0, dvs_q}) quo_q <= quo_q + OP_W'(1);
`endif
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator transaction sequencer: key entry, arithmetic, BCD conversion and LCD buffer writes.
// Division rounding is selected with CALC_DIV_ROUND_EN (see calc_divider).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OP_W   = 14,
    parameter int unsigned RES_W  = 28
) (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       disp_we,
    output logic [4:0] disp_addr,
    output logic [7:0] disp_data,
    output logic       busy,
    output logic       err
);
    localparam int unsigned NBcd  = 2 * DIGITS;
    localparam int unsigned BcdW  = 4 * NBcd;
    localparam int unsigned DCntW = $clog2(DIGITS + 1);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cursor_q;
    logic [OP_W-1:0]    a_q, b_q, div_quo;
    logic [DCntW-1:0]   a_cnt_q, b_cnt_q;
    op_e                op_q, key_op;
    logic [RES_W-1:0]   res_q;
    logic [BcdW-1:0]    bcd_q, bcd_adj;
    logic               neg_q, err_q, div_start, div_done;
    logic               disp_we_q;
    logic [4:0]         disp_addr_q;
    logic [7:0]         disp_data_q;
    logic               clr_key, key_acc, is_digit, is_op, is_eq, echo_en;
    logic [7:0]         echo_ch, emit_char;
    logic [3:0]         emit_pos, msd, emit_digit;

    assign clr_key  = key_valid && (key_code == KeyClr);
    assign key_acc  = key_valid && key_ready && !clr_key;
    assign is_digit = key_code <= 4'd9;
    assign is_op    = (key_code >= KeyAdd) && (key_code <= KeyDiv);
    assign is_eq    = key_code == KeyEq;
    // Codes 10..13 map onto OpAdd..OpDiv through their low two bits.
    assign key_op   = op_e'(key_code[1:0] - 2'd2);

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) state_q <= StClr;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_key) begin
            state_d = StClr;
        end else begin
            unique case (state_q)
                StClr:  if (cnt_q == 5'd31) state_d = StEntA;
                StEntA: if (key_acc && is_op) state_d = StEntB;
                        else if (key_acc && is_eq) state_d = StConv;
                StEntB: if (key_acc && is_eq) state_d = StCalc;
                StCalc: if (op_q != OpDiv) state_d = StConv;
                        else if (b_q == '0) state_d = StEmit;
                        else state_d = StDiv;
                StDiv:  if (div_done) state_d = StConv;
                StConv: if (cnt_q == 5'(RES_W - 1)) state_d = StEmit;
                StEmit: if (cnt_q == 5'd15) state_d = StDone;
                StDone: state_d = StDone;
                default: state_d = StClr;
            endcase
        end
    end

    always_comb begin
        key_ready = 1'b0;
        unique case (state_q)
            StEntA, StEntB, StDone: key_ready = 1'b1;
            default:                key_ready = 1'b0;
        endcase
        busy = !key_ready;
    end

    always_comb begin
        echo_en = 1'b0;
        echo_ch = ChBlank;
        if (key_acc && state_q == StEntA) begin
            if (is_digit && a_cnt_q < DCntW'(DIGITS)) begin
                echo_en = 1'b1;
                echo_ch = digit_char(key_code);
            end else if (is_op) begin
                echo_en = 1'b1;
                echo_ch = op_char(key_op);
            end
        end else if (key_acc && state_q == StEntB) begin
            if (is_digit && b_cnt_q < DCntW'(DIGITS)) begin
                echo_en = 1'b1;
                echo_ch = digit_char(key_code);
            end else if (is_eq) begin
                echo_en = 1'b1;
                echo_ch = ChEq;
            end
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NBcd; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Line2 column to character: emit_pos counts digit positions from the right edge.
    always_comb begin
        emit_pos   = 4'd15 - cnt_q[3:0];
        msd        = '0;
        emit_digit = '0;
        for (int i = 0; i < NBcd; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = 4'(i);
            if (4'(i) == emit_pos) emit_digit = bcd_q[4*i +: 4];
        end
        emit_char = ChBlank;
        if (err_q) begin
            if (emit_pos == 4'd2)      emit_char = ChE;
            else if (emit_pos <= 4'd1) emit_char = ChR;
        end else if (emit_pos <= msd) begin
            emit_char = digit_char(emit_digit);
        end else if (neg_q && emit_pos == msd + 4'd1) begin
            emit_char = ChMinus;
        end
    end

    assign div_start = (state_q == StCalc) && (op_q == OpDiv) && (b_q != '0) && !clr_key;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cursor_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            op_q        <= OpAdd;
            res_q       <= '0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            disp_we_q   <= 1'b0;
            disp_addr_q <= '0;
            disp_data_q <= ChBlank;
        end else begin
            disp_we_q <= 1'b0;
            if (clr_key) begin
                cnt_q <= '0;
            end else begin
                if (echo_en && !cursor_q[4]) begin
                    disp_we_q   <= 1'b1;
                    disp_addr_q <= cursor_q;
                    disp_data_q <= echo_ch;
                    cursor_q    <= cursor_q + 5'd1;
                end
                unique case (state_q)
                    StClr: begin
                        disp_we_q   <= 1'b1;
                        disp_addr_q <= cnt_q;
                        disp_data_q <= ChBlank;
                        cnt_q       <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            err_q    <= 1'b0;
                            a_q      <= '0;
                            b_q      <= '0;
                            a_cnt_q  <= '0;
                            b_cnt_q  <= '0;
                            cursor_q <= '0;
                        end
                    end
                    StEntA: if (key_acc) begin
                        if (is_digit && a_cnt_q < DCntW'(DIGITS)) begin
                            a_q     <= a_q * OP_W'(10) + OP_W'(key_code);
                            a_cnt_q <= a_cnt_q + DCntW'(1);
                        end else if (is_op) begin
                            op_q <= key_op;
                        end else if (is_eq) begin
                            res_q <= RES_W'(a_q);
                            neg_q <= 1'b0;
                            bcd_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                    StEntB: if (key_acc && is_digit && b_cnt_q < DCntW'(DIGITS)) begin
                        b_q     <= b_q * OP_W'(10) + OP_W'(key_code);
                        b_cnt_q <= b_cnt_q + DCntW'(1);
                    end
                    StCalc: begin
                        cnt_q <= '0;
                        bcd_q <= '0;
                        neg_q <= 1'b0;
                        unique case (op_q)
                            OpAdd: res_q <= RES_W'(a_q) + RES_W'(b_q);
                            OpSub: if (b_q > a_q) begin
                                neg_q <= 1'b1;
                                res_q <= RES_W'(b_q - a_q);
                            end else begin
                                res_q <= RES_W'(a_q - b_q);
                            end
                            OpMul: res_q <= RES_W'(a_q) * RES_W'(b_q);
                            OpDiv: if (b_q == '0) err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    StDiv: if (div_done) begin
                        res_q <= RES_W'(div_quo);
                        cnt_q <= '0;
                    end
                    StConv: begin
                        bcd_q <= {bcd_adj[BcdW-2:0], res_q[RES_W-1]};
                        res_q <= {res_q[RES_W-2:0], 1'b0};
                        cnt_q <= (cnt_q == 5'(RES_W - 1)) ? 5'd0 : cnt_q + 5'd1;
                    end
                    StEmit: begin
                        disp_we_q   <= 1'b1;
                        disp_addr_q <= {1'b1, cnt_q[3:0]};
                        disp_data_q <= emit_char;
                        cnt_q       <= cnt_q + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    calc_divider #(
        .OP_W(OP_W)
    ) u_divider (
        .clk_100hz(clk_100hz),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_q),
        .divisor  (b_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign disp_we   = disp_we_q;
    assign disp_addr = disp_addr_q;
    assign disp_data = disp_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected buffer writes are queued, a monitor pops and compares.
module tb_calc_sequencer;

    logic       clk_100hz = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready, disp_we, busy, err;
    logic [4:0] disp_addr;
    logic [7:0] disp_data;

    calc_sequencer dut (
        .clk_100hz(clk_100hz),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .disp_we  (disp_we),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk_100hz = ~clk_100hz;

    int cyc = 0;
    always @(posedge clk_100hz) cyc <= cyc + 1;

    logic [12:0] exp_q[$];
    logic [12:0] exp_w;
    int tests = 0, failed = 0;
    int acc_cyc = 0, wr_cyc = 0, eq_cyc = 0;

    always @(negedge clk_100hz) begin
        if (!rst && disp_we) begin
            tests++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         disp_addr, disp_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({disp_addr, disp_data} !== exp_w) begin
                    failed++;
                    $display("FAIL disp_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             disp_addr, disp_data, exp_w[12:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] lcd(input logic [7:0] c);
        if (c == "*") return 8'hD7;
        if (c == "/") return 8'hF7;
        return c;
    endfunction

    function automatic logic [3:0] code_of(input logic [7:0] c);
        case (c)
            "+":     return 4'd10;
            "-":     return 4'd11;
            "*":     return 4'd12;
            "/":     return 4'd13;
            "=":     return 4'd14;
            "C":     return 4'd15;
            default: return 4'(c - 8'd48);
        endcase
    endfunction

    task automatic expect_str(input int base, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({5'(base + i), lcd(s[i])});
    endtask

    task automatic expect_line2(input string s);
        logic [7:0] c;
        for (int i = 0; i < 16; i++) begin
            c = 8'h20;
            if (i >= 16 - s.len()) c = lcd(s[i - (16 - s.len())]);
            exp_q.push_back({5'(16 + i), c});
        end
    endtask

    task automatic expect_blanks();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'h20});
    endtask

    task automatic press(input logic [7:0] c);
        @(negedge clk_100hz);
        key_valid = 1'b1;
        key_code  = code_of(c);
        @(posedge clk_100hz);
        #1 acc_cyc = cyc;
        @(negedge clk_100hz);
        key_valid = 1'b0;
    endtask

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk_100hz);
            n++;
        end
        repeat (4) @(negedge clk_100hz);
        check({name, " pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_clear(input string name);
        expect_blanks();
        press("C");
        wait_drain(name);
        check({name, " key_ready"}, key_ready, 1);
        check({name, " err"}, err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        expect_blanks();
        repeat (2) @(negedge clk_100hz);
        check("reset key_ready", key_ready, 0);
        check("reset disp_we", disp_we, 0);
        check("reset disp_addr", disp_addr, 0);
        check("reset disp_data", disp_data, 32);
        check("reset busy", busy, 1);
        check("reset err", err, 0);
        rst = 1'b0;
        wait_drain("reset_sweep");
        check("idle key_ready", key_ready, 1);
        check("idle busy", busy, 0);

        expect_str(0, "12+34=");
        expect_line2("46");
        press_str("12+34=");
        eq_cyc = acc_cyc;
        wait_drain("add");
        check("add latency", wr_cyc - eq_cyc, 45);
        check("add done busy", busy, 0);
        do_clear("clear1");

        // The '8' lands while the result is being converted and must be dropped.
        expect_str(0, "5-9=");
        expect_line2("-4");
        press_str("5-9=");
        eq_cyc = acc_cyc;
        press("8");
        wait_drain("sub");
        check("sub latency", wr_cyc - eq_cyc, 45);
        check("sub err", err, 0);
        do_clear("clear2");

        expect_str(0, "9999*9999=");
        expect_line2("99980001");
        press_str("9999*9999=");
        wait_drain("mul");
        do_clear("clear3");

        expect_str(0, "7/0=");
        expect_line2("Err");
        press_str("7/0=");
        wait_drain("div0");
        check("div0 err", err, 1);
        do_clear("clear_div0");

        expect_str(0, "7/2=");
`ifdef CALC_DIV_ROUND_EN
        expect_line2("4");
`else
        expect_line2("3");
`endif
        press_str("7/2=");
        eq_cyc = acc_cyc;
        wait_drain("div");
`ifdef CALC_DIV_ROUND_EN
        check("div latency", wr_cyc - eq_cyc, 60);
`else
        check("div latency", wr_cyc - eq_cyc, 59);
`endif
        do_clear("clear4");

        expect_str(0, "7/2=");
        press_str("7/2=");
        press("5");
        check("div busy", busy, 1);
        check("div key_ready", key_ready, 0);
        repeat (2) @(negedge clk_100hz);
        expect_blanks();
        press("C");
        wait_drain("div_abort");
        repeat (60) @(negedge clk_100hz);
        check("abort key_ready", key_ready, 1);
        check("abort err", err, 0);

        expect_str(0, "1234+6=");
        expect_line2("1240");
        press_str("12345+6=");
        wait_drain("digit_limit");
        press("7");
        repeat (5) @(negedge clk_100hz);
        check("done busy", busy, 0);
        check("done key_ready", key_ready, 1);
        do_clear("clear5");

        expect_str(0, "3-3=");
        expect_line2("0");
        press_str("3-3=");
        wait_drain("zero");
        check("zero err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
